ex_unit: RTL

//  Execute stage, directly upstream of the memory stage. Latches one instruction from decode,

---
 rtl/ex_unit.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ex_unit.sv
// Execute stage: latches one decoded instruction, runs single-cycle ALU ops or a 32-step
// restoring divider, and hands the result and the data SRAM request to the memory stage.
module ex_unit #(
  parameter int ID_EX_W   = 140,
  parameter int EX_ME_W   = 71,
  parameter int DIV_STEPS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ID_Valid,
  output logic               EX_Unit_Ready,
  input  logic [ID_EX_W-1:0] ID_to_EX_Bus,
  input  logic               ME_Unit_Ready,
  output logic               EX_Valid,
  output logic [EX_ME_W-1:0] EX_to_ME_Bus,
  output logic               data_sram_en,
  output logic [3:0]         data_sram_we,
  output logic [31:0]        data_sram_addr,
  output logic [31:0]        data_sram_wdata
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);

  logic [31:0] in_pc, in_src1, in_src2, in_rkd;
  logic [3:0]  in_op;
  logic        in_mem_we, in_rfm, in_gr_we, in_is_div, in_signed;
  logic [4:0]  in_dest;
  logic [31:0] in_a_mag, in_b_mag;

  logic        ex_valid_q, ex_valid_d;
  logic [31:0] pc_q, src1_q, src2_q, rkd_q;
  logic [3:0]  op_q;
  logic        mem_we_q, rfm_q, gr_we_q;
  logic [4:0]  dest_q;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;

  logic        accept, handoff, is_div, ready_go;
  logic        step_ge, q_neg, r_neg;
  logic [31:0] step_diff, q_fix, r_fix, div_res, alu_res, alu_result;

  assign in_pc     = ID_to_EX_Bus[139:108];
  assign in_op     = ID_to_EX_Bus[107:104];
  assign in_src1   = ID_to_EX_Bus[103:72];
  assign in_src2   = ID_to_EX_Bus[71:40];
  assign in_rkd    = ID_to_EX_Bus[39:8];
  assign in_mem_we = ID_to_EX_Bus[7];
  assign in_rfm    = ID_to_EX_Bus[6];
  assign in_gr_we  = ID_to_EX_Bus[5];
  assign in_dest   = ID_to_EX_Bus[4:0];

  // Ops 12/13 are signed, 14/15 unsigned; bit 0 selects remainder over quotient.
  assign in_is_div = (in_op[3:2] == 2'b11);
  assign in_signed = ~in_op[1];
  assign in_a_mag  = (in_signed && in_src1[31]) ? (32'd0 - in_src1) : in_src1;
  assign in_b_mag  = (in_signed && in_src2[31]) ? (32'd0 - in_src2) : in_src2;

  assign is_div        = (op_q[3:2] == 2'b11);
  assign ready_go      = ~is_div | (state_q == S_DONE);
  assign EX_Valid      = ex_valid_q & ready_go;
  assign EX_Unit_Ready = ~ex_valid_q | (ready_go & ME_Unit_Ready);
  assign accept        = ID_Valid & EX_Unit_Ready;
  assign handoff       = EX_Valid & ME_Unit_Ready;

  always_comb begin
    alu_res = 32'd0;
    case (op_q)
      4'd0:    alu_res = src1_q + src2_q;
      4'd1:    alu_res = src1_q - src2_q;
      4'd2:    alu_res = {31'd0, ($signed(src1_q) < $signed(src2_q))};
      4'd3:    alu_res = {31'd0, (src1_q < src2_q)};
      4'd4:    alu_res = src1_q & src2_q;
      4'd5:    alu_res = src1_q | src2_q;
      4'd6:    alu_res = ~(src1_q | src2_q);
      4'd7:    alu_res = src1_q ^ src2_q;
      4'd8:    alu_res = src1_q << src2_q[4:0];
      4'd9:    alu_res = src1_q >> src2_q[4:0];
      4'd10:   alu_res = $unsigned($signed(src1_q) >>> src2_q[4:0]);
      4'd11:   alu_res = src2_q;
      default: alu_res = 32'd0;
    endcase
  end

  // Sign fix-up of the magnitude result; a zero divisor bypasses it entirely.
  always_comb begin
    q_neg = ~op_q[1] & (src1_q[31] ^ src2_q[31]);
    r_neg = ~op_q[1] & src1_q[31];
    if (src2_q == 32'd0) begin
      q_fix = 32'hFFFF_FFFF;
      r_fix = src1_q;
    end else begin
      q_fix = q_neg ? (32'd0 - quo_q) : quo_q;
      r_fix = r_neg ? (32'd0 - rem_q) : rem_q;
    end
    div_res = op_q[0] ? r_fix : q_fix;
  end

  assign alu_result = is_div ? div_res : alu_res;

  // Partial remainder is always below the divisor, so the low 32 bits of the difference suffice.
  assign step_ge   = ({rem_q, quo_q[31]} >= {1'b0, dvs_q});
  assign step_diff = {rem_q[30:0], quo_q[31]} - dvs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    case (state_q)
      S_IDLE: begin
        if (accept && in_is_div) begin
          state_d = S_RUN;
          cnt_d   = 6'd0;
          rem_d   = 32'd0;
          quo_d   = in_a_mag;
          dvs_d   = in_b_mag;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (step_ge) begin
          rem_d = step_diff;
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = {rem_q[30:0], quo_q[31]};
          quo_d = {quo_q[30:0], 1'b0};
        end
        if (cnt_q == LAST_STEP) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (handoff && accept && in_is_div) begin
          state_d = S_RUN;
          cnt_d   = 6'd0;
          rem_d   = 32'd0;
          quo_d   = in_a_mag;
          dvs_d   = in_b_mag;
        end else if (handoff) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if (accept) begin
      ex_valid_d = 1'b1;
    end else if (handoff) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      pc_q       <= 32'd0;
      op_q       <= 4'd0;
      src1_q     <= 32'd0;
      src2_q     <= 32'd0;
      rkd_q      <= 32'd0;
      mem_we_q   <= 1'b0;
      rfm_q      <= 1'b0;
      gr_we_q    <= 1'b0;
      dest_q     <= 5'd0;
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      dvs_q      <= 32'd0;
    end else begin
      ex_valid_q <= ex_valid_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      if (accept) begin
        pc_q     <= in_pc;
        op_q     <= in_op;
        src1_q   <= in_src1;
        src2_q   <= in_src2;
        rkd_q    <= in_rkd;
        mem_we_q <= in_mem_we;
        rfm_q    <= in_rfm;
        gr_we_q  <= in_gr_we;
        dest_q   <= in_dest;
      end
    end
  end

  // The request fires only on the handoff cycle, so a stalled access is never repeated.
  assign data_sram_en    = handoff & (mem_we_q | rfm_q);
  assign data_sram_we    = {4{data_sram_en & mem_we_q}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rkd_q;
  assign EX_to_ME_Bus    = {pc_q, alu_result, rfm_q, gr_we_q, dest_q};

endmodule
